// File: rtl/fpga_bram_arb_pkg.sv
// Shared widths, limits and payload type for the single-port BRAM arbiter.
// Optional statistics (FPGA_BRAM_ARB_STATS_EN) use the saturating helper below.
package fpga_bram_arb_pkg;

   localparam int DEFAULT_DATA_WIDTH    = 64;
   localparam int DEFAULT_ADDRESS_WIDTH = 32;
   localparam int MAX_NUM_REQ           = 4;
   localparam int STAT_WIDTH            = 32;

   typedef struct packed {
      logic                             we;
      logic [DEFAULT_ADDRESS_WIDTH-1:0] addr;
      logic [DEFAULT_DATA_WIDTH-1:0]    wdata;
   } bram_req_t;

   function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from a rotating pointer.
// Pointer moves to one past the winner on every grant; grants are suppressed during reset.
module rr_arbiter #(
   parameter int N = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] gnt_idx
);

   localparam int IW = $clog2(N);

   logic [IW-1:0] ptr;
   logic [IW-1:0] cand;
   logic          found;

   always_comb begin
      found   = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int k = 0; k < N; k++) begin
         cand = IW'((int'(ptr) + k) % N);
         if (!found && req[cand]) begin
            found   = 1'b1;
            gnt_idx = cand;
         end
      end
      gnt = '0;
      if (found && !rst) begin
         gnt[gnt_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (found) begin
         ptr <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
      end
   end

endmodule

// File: rtl/fpga_bram_arbiter.sv
// Shares one single-port BRAM among NUM_REQ requesters with round-robin grants and
// routes the 1-cycle read data back to its issuer. Stats ports: FPGA_BRAM_ARB_STATS_EN.
module fpga_bram_arbiter
   import fpga_bram_arb_pkg::*;
#(
   parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
   parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
   parameter int NUM_REQ       = 2
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [NUM_REQ-1:0]                     req,
   input  logic [NUM_REQ-1:0]                     req_we,
   input  logic [NUM_REQ-1:0][ADDRESS_WIDTH-1:0]  req_addr,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     req_wdata,
   output logic [NUM_REQ-1:0]                     gnt,
   output logic [NUM_REQ-1:0]                     rvalid,
   output logic [DATA_WIDTH-1:0]                  rdata,
   output logic                                   bram_ena,
   output logic                                   bram_wea,
   output logic [ADDRESS_WIDTH-1:0]               bram_addra,
   output logic [DATA_WIDTH-1:0]                  bram_dina,
   input  logic [DATA_WIDTH-1:0]                  bram_douta,
   input  logic                                   bram_error,
   output logic                                   err
`ifdef FPGA_BRAM_ARB_STATS_EN
   ,
   output logic [NUM_REQ-1:0][STAT_WIDTH-1:0]     grant_cnt,
   output logic [NUM_REQ-1:0][STAT_WIDTH-1:0]     wait_cnt
`endif
);

   localparam int IDX_W = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > MAX_NUM_REQ) begin : g_bad_num_req
      $error("fpga_bram_arbiter: NUM_REQ must be within 2..%0d", MAX_NUM_REQ);
   end

   logic [IDX_W-1:0] gnt_idx;
   logic             gnt_any;
   logic             pend_vld;
   logic [IDX_W-1:0] pend_owner;

   rr_arbiter #(
      .N (NUM_REQ)
   ) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign gnt_any = |gnt;

   // Idle cycles drive zeros so the BRAM pins never float to X.
   always_comb begin
      bram_ena   = 1'b0;
      bram_wea   = 1'b0;
      bram_addra = '0;
      bram_dina  = '0;
      if (gnt_any) begin
         bram_ena   = 1'b1;
         bram_wea   = req_we[gnt_idx];
         bram_addra = req_addr[gnt_idx];
         bram_dina  = req_wdata[gnt_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_vld   <= 1'b0;
         pend_owner <= '0;
         err        <= 1'b0;
      end else begin
         pend_vld <= gnt_any && !req_we[gnt_idx];
         if (gnt_any) begin
            pend_owner <= gnt_idx;
         end
         if (bram_error) begin
            err <= 1'b1;
         end
      end
   end

   // A read in flight when reset arrives must not surface during reset.
   always_comb begin
      rvalid = '0;
      rdata  = '0;
      if (pend_vld && !rst) begin
         rvalid[pend_owner] = 1'b1;
         rdata              = bram_douta;
      end
   end

`ifdef FPGA_BRAM_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         grant_cnt <= '0;
         wait_cnt  <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
               grant_cnt[i] <= sat_inc(grant_cnt[i]);
            end
            if (req[i] && !gnt[i]) begin
               wait_cnt[i] <= sat_inc(wait_cnt[i]);
            end
         end
      end
   end
`else
   // Without statistics the arbiter carries no counters.
`endif

endmodule

// File: tb/tb_fpga_bram_arbiter.sv
// Self-checking bench for fpga_bram_arbiter with a behavioural BRAM and reference model.
module tb_fpga_bram_arbiter;

   localparam int DW = 64;
   localparam int AW = 32;
   localparam int NR = 2;

   logic                    clk;
   logic                    rst;
   logic [NR-1:0]           req;
   logic [NR-1:0]           req_we;
   logic [NR-1:0][AW-1:0]   req_addr;
   logic [NR-1:0][DW-1:0]   req_wdata;
   logic [NR-1:0]           gnt;
   logic [NR-1:0]           rvalid;
   logic [DW-1:0]           rdata;
   logic                    bram_ena;
   logic                    bram_wea;
   logic [AW-1:0]           bram_addra;
   logic [DW-1:0]           bram_dina;
   logic [DW-1:0]           bram_douta;
   logic                    bram_error;
   logic                    err;
`ifdef FPGA_BRAM_ARB_STATS_EN
   logic [NR-1:0][31:0]     grant_cnt;
   logic [NR-1:0][31:0]     wait_cnt;
`endif

   int n_vec = 0;
   int n_err = 0;

   // reference model state
   int            m_ptr;
   bit            m_pv;
   int            m_owner;
   logic [63:0]   m_pdata;
   bit            m_err;
   logic [NR-1:0] last_gnt;
   logic [63:0]   ref_mem [int];
   int            m_gcnt [NR];
   int            m_wcnt [NR];

   // behavioural BRAM device
   bit            dev_written [256];
   logic [63:0]   dev_mem [256];

   fpga_bram_arbiter #(
      .DATA_WIDTH    (DW),
      .ADDRESS_WIDTH (AW),
      .NUM_REQ       (NR)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .gnt        (gnt),
      .rvalid     (rvalid),
      .rdata      (rdata),
      .bram_ena   (bram_ena),
      .bram_wea   (bram_wea),
      .bram_addra (bram_addra),
      .bram_dina  (bram_dina),
      .bram_douta (bram_douta),
      .bram_error (bram_error),
      .err        (err)
`ifdef FPGA_BRAM_ARB_STATS_EN
      ,
      .grant_cnt  (grant_cnt),
      .wait_cnt   (wait_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] init_val(int a);
      if (a == 16) return 64'hDEAD_BEEF_CAFE_F00D;
      return {32'h5A5A_0000 + 32'(a), 32'(a) * 32'h0101_0101};
   endfunction

   function automatic logic [63:0] ref_rd(int a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return init_val(a);
   endfunction

   always @(posedge clk) begin
      if (bram_ena === 1'b1) begin
         if (bram_wea) begin
            dev_mem[bram_addra[7:0]]     <= bram_dina;
            dev_written[bram_addra[7:0]] <= 1'b1;
         end else begin
            bram_douta <= dev_written[bram_addra[7:0]] ? dev_mem[bram_addra[7:0]]
                                                       : init_val(int'(bram_addra[7:0]));
         end
      end
   end

   // Winner = asserted requester at the smallest rotational distance from the pointer.
   function automatic int exp_winner();
      int best;
      int best_d;
      best   = -1;
      best_d = NR;
      for (int i = 0; i < NR; i++) begin
         int d;
         d = (i - m_ptr + NR) % NR;
         if (req[i] && d < best_d) begin
            best   = i;
            best_d = d;
         end
      end
      return best;
   endfunction

   // Advance one clock and update the model from the inputs seen at that edge.
   task automatic tick();
      int w;
      @(posedge clk);
      w = exp_winner();
      if (rst) begin
         m_ptr    = 0;
         m_pv     = 0;
         m_err    = 0;
         last_gnt = '0;
         for (int i = 0; i < NR; i++) begin
            m_gcnt[i] = 0;
            m_wcnt[i] = 0;
         end
      end else begin
         last_gnt = '0;
         m_pv     = 0;
         if (w >= 0) begin
            last_gnt[w] = 1'b1;
            m_ptr       = (w + 1) % NR;
            if (!req_we[w]) begin
               m_pv    = 1;
               m_owner = w;
               m_pdata = ref_rd(int'(req_addr[w][7:0]));
            end else begin
               ref_mem[int'(req_addr[w][7:0])] = req_wdata[w];
            end
         end
         if (bram_error) m_err = 1;
         for (int i = 0; i < NR; i++) begin
            if (w == i) m_gcnt[i]++;
            else if (req[i]) m_wcnt[i]++;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req = 2'b11;
      req_we = '0;
      req_addr[0] = 32'h1;
      req_addr[1] = 32'h2;
      tick();
      tick();
      @(negedge clk);
      n_vec++; if (gnt !== 2'b00) begin n_err++; $display("FAIL reset_gnt: got %b want 00", gnt); end
      n_vec++; if (bram_ena !== 1'b0) begin n_err++; $display("FAIL reset_ena: got %b want 0", bram_ena); end
      n_vec++; if (rvalid !== 2'b00) begin n_err++; $display("FAIL reset_rvalid: got %b want 00", rvalid); end
      n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err); end
      tick();
      rst = 1'b0;
      @(negedge clk);
      n_vec++; if (gnt !== 2'b01) begin n_err++; $display("FAIL reset_first_gnt: got %b want 01", gnt); end
   endtask

   task automatic test_single_read();
      tick();
      req = 2'b01;
      req_we = '0;
      req_addr[0] = 32'h10;
      @(negedge clk);
      n_vec++; if (gnt !== 2'b01) begin n_err++; $display("FAIL single_gnt: got %b want 01", gnt); end
      n_vec++; if (bram_ena !== 1'b1 || bram_wea !== 1'b0) begin n_err++; $display("FAIL single_ena_wea: got %b%b want 10", bram_ena, bram_wea); end
      n_vec++; if (bram_addra !== 32'h10) begin n_err++; $display("FAIL single_addr: got %h want 00000010", bram_addra); end
      tick();
      req = 2'b00;
      @(negedge clk);
      n_vec++; if (rvalid !== 2'b01) begin n_err++; $display("FAIL single_rvalid: got %b want 01", rvalid); end
      n_vec++; if (rdata !== 64'hDEAD_BEEF_CAFE_F00D) begin n_err++; $display("FAIL single_rdata: got %h want deadbeefcafef00d", rdata); end
   endtask

   task automatic test_contention();
      int seq [6];
      int prev;
      logic [NR-1:0] e;
`ifdef FPGA_BRAM_ARB_STATS_EN
      logic [NR-1:0][31:0] g0;
`endif
      seq = '{0, 1, 0, 1, 0, 1};
      // a lone grant to requester 1 parks the pointer at 0
      tick();
      req = 2'b10;
      req_we = '0;
      req_addr[1] = 32'h31;
      tick();
`ifdef FPGA_BRAM_ARB_STATS_EN
      g0 = grant_cnt;
`endif
      req = 2'b11;
      req_addr[0] = 32'h30;
      prev = -1;
      for (int c = 0; c < 6; c++) begin
         if (c > 0) tick();
         @(negedge clk);
         e = '0;
         e[seq[c]] = 1'b1;
         n_vec++; if (gnt !== e) begin n_err++; $display("FAIL cont_gnt[%0d]: got %b want %b", c, gnt, e); end
         if (prev >= 0) begin
            e = '0;
            e[prev] = 1'b1;
            n_vec++; if (rvalid !== e) begin n_err++; $display("FAIL cont_rvalid[%0d]: got %b want %b", c, rvalid, e); end
            n_vec++; if (rdata !== ref_rd(prev == 0 ? 'h30 : 'h31)) begin n_err++; $display("FAIL cont_rdata[%0d]: got %h want %h", c, rdata, ref_rd(prev == 0 ? 'h30 : 'h31)); end
         end
         prev = seq[c];
      end
      tick();
      req = 2'b00;
      @(negedge clk);
      e = '0;
      e[prev] = 1'b1;
      n_vec++; if (rvalid !== e) begin n_err++; $display("FAIL cont_last_rvalid: got %b want %b", rvalid, e); end
`ifdef FPGA_BRAM_ARB_STATS_EN
      n_vec++; if (grant_cnt[0] - g0[0] !== 32'd3 || grant_cnt[1] - g0[1] !== 32'd3) begin
         n_err++; $display("FAIL cont_grant_cnt: got +%0d,+%0d want +3,+3", grant_cnt[0] - g0[0], grant_cnt[1] - g0[1]);
      end
`endif
   endtask

   task automatic test_write_read();
      tick();
      req = 2'b10;
      req_we = 2'b10;
      req_addr[1] = 32'h20;
      req_wdata[1] = 64'h1234;
      @(negedge clk);
      n_vec++; if (gnt !== 2'b10) begin n_err++; $display("FAIL wr_gnt: got %b want 10", gnt); end
      n_vec++; if (bram_wea !== 1'b1 || bram_dina !== 64'h1234) begin n_err++; $display("FAIL wr_bram: got wea=%b dina=%h want wea=1 dina=1234", bram_wea, bram_dina); end
      tick();
      req = 2'b01;
      req_we = 2'b00;
      req_addr[0] = 32'h20;
      @(negedge clk);
      n_vec++; if (gnt !== 2'b01) begin n_err++; $display("FAIL wr_rd_gnt: got %b want 01", gnt); end
      n_vec++; if (rvalid !== 2'b00) begin n_err++; $display("FAIL wr_no_rvalid: got %b want 00", rvalid); end
      tick();
      req = 2'b00;
      @(negedge clk);
      n_vec++; if (rvalid !== 2'b01 || rdata !== 64'h1234) begin n_err++; $display("FAIL wr_rd_data: got rvalid=%b rdata=%h want 01/1234", rvalid, rdata); end
   endtask

   task automatic test_reset_mid_read();
      tick();
      req = 2'b01;
      req_we = 2'b00;
      req_addr[0] = 32'h10;
      @(negedge clk);
      n_vec++; if (gnt !== 2'b01) begin n_err++; $display("FAIL rmr_gnt: got %b want 01", gnt); end
      tick();
      rst = 1'b1;
      req = 2'b00;
      @(negedge clk);
      n_vec++; if (rvalid !== 2'b00) begin n_err++; $display("FAIL rmr_rvalid_in_rst: got %b want 00", rvalid); end
      tick();
      rst = 1'b0;
      @(negedge clk);
      n_vec++; if (rvalid !== 2'b00) begin n_err++; $display("FAIL rmr_rvalid_after: got %b want 00", rvalid); end
      tick();
      req = 2'b11;
      @(negedge clk);
      n_vec++; if (gnt !== 2'b01) begin n_err++; $display("FAIL rmr_ptr: got %b want 01", gnt); end
      tick();
      req = 2'b00;
   endtask

   task automatic test_error();
      tick();
      bram_error = 1'b1;
      @(negedge clk);
      n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL err_early: got %b want 0", err); end
      tick();
      bram_error = 1'b0;
      @(negedge clk);
      n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL err_set: got %b want 1", err); end
      tick();
      tick();
      tick();
      @(negedge clk);
      n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b want 1", err); end
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL err_clear: got %b want 0", err); end
   endtask

   task automatic test_random();
      int w;
      logic [NR-1:0] e_gnt, e_rv;
      logic          e_ena, e_wea;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_din, e_rd;
      for (int c = 0; c < 400; c++) begin
         tick();
         for (int i = 0; i < NR; i++) begin
            if (!req[i] || last_gnt[i]) begin
               req[i]       = ($urandom % 4) != 0;
               req_we[i]    = ($urandom % 3) == 0;
               req_addr[i]  = 32'($urandom % 64);
               req_wdata[i] = {$urandom, $urandom};
            end
         end
         bram_error = ($urandom % 97) == 0;
         @(negedge clk);
         w = exp_winner();
         e_gnt = '0; e_ena = 0; e_wea = 0; e_addr = '0; e_din = '0;
         if (w >= 0) begin
            e_gnt[w] = 1'b1; e_ena = 1'b1; e_wea = req_we[w];
            e_addr = req_addr[w]; e_din = req_wdata[w];
         end
         e_rv = '0; e_rd = '0;
         if (m_pv) begin e_rv[m_owner] = 1'b1; e_rd = m_pdata; end
         n_vec++; if (gnt !== e_gnt) begin n_err++; $display("FAIL rnd_gnt c%0d: got %b want %b", c, gnt, e_gnt); end
         n_vec++; if (bram_ena !== e_ena || bram_wea !== e_wea) begin n_err++; $display("FAIL rnd_ena_wea c%0d: got %b%b want %b%b", c, bram_ena, bram_wea, e_ena, e_wea); end
         n_vec++; if (bram_addra !== e_addr || bram_dina !== e_din) begin n_err++; $display("FAIL rnd_bus c%0d: got %h/%h want %h/%h", c, bram_addra, bram_dina, e_addr, e_din); end
         n_vec++; if (rvalid !== e_rv || rdata !== e_rd) begin n_err++; $display("FAIL rnd_read c%0d: got %b/%h want %b/%h", c, rvalid, rdata, e_rv, e_rd); end
         n_vec++; if (err !== m_err) begin n_err++; $display("FAIL rnd_err c%0d: got %b want %b", c, err, m_err); end
      end
      tick();
      req = '0;
      bram_error = 1'b0;
      @(negedge clk);
`ifdef FPGA_BRAM_ARB_STATS_EN
      for (int i = 0; i < NR; i++) begin
         n_vec++; if (grant_cnt[i] !== 32'(m_gcnt[i])) begin n_err++; $display("FAIL rnd_grant_cnt[%0d]: got %0d want %0d", i, grant_cnt[i], m_gcnt[i]); end
         n_vec++; if (wait_cnt[i] !== 32'(m_wcnt[i])) begin n_err++; $display("FAIL rnd_wait_cnt[%0d]: got %0d want %0d", i, wait_cnt[i], m_wcnt[i]); end
      end
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded its time bound");
      $fatal(1);
   end

   initial begin
      rst        = 1'b1;
      req        = '0;
      req_we     = '0;
      req_addr   = '0;
      req_wdata  = '0;
      bram_error = 1'b0;
      m_ptr      = 0;
      m_pv       = 0;
      m_owner    = 0;
      m_pdata    = '0;
      m_err      = 0;
      last_gnt   = '0;
      test_reset();
      test_single_read();
      test_contention();
      test_write_read();
      test_reset_mid_read();
      test_error();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
